// File: rtl/if_fetch_pkg.sv
// Shared widths, control encodings and fetch FSM states for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;
  localparam int BYTE_LEN = 8;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic BRANCH_ENABLE = 1'b1;
  localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_BUSY = 2'd1,
    IF_DONE = 2'd2
  } if_state_e;

  // Little-endian assembly: the fourth byte arrives last and lands on top.
  function automatic logic [INST_LEN-1:0] assemble_word(input logic [23:0] low_bytes,
                                                        input logic [BYTE_LEN-1:0] top_byte);
    return {top_byte, low_bytes};
  endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache (built only with ICACHE_EN).
// Combinational lookup, synchronous fill; only the valid bits are reset.
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_LEN-3:0]   lookup_word,
  output logic                  hit,
  output logic [INST_LEN-1:0]   rd_data,
  input  logic                  fill_en,
  input  logic [ADDR_LEN-3:0]   fill_word,
  input  logic [INST_LEN-1:0]   fill_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_LEN - 2 - IDX_W;

  logic [LINES-1:0]    line_valid;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [INST_LEN-1:0] data_mem [LINES];

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign lookup_idx = lookup_word[IDX_W-1:0];
  assign lookup_tag = lookup_word[ADDR_LEN-3:IDX_W];
  assign fill_idx   = fill_word[IDX_W-1:0];
  assign fill_tag   = fill_word[ADDR_LEN-3:IDX_W];

  assign hit     = line_valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
  assign rd_data = data_mem[lookup_idx];

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: reads a 32-bit word byte-by-byte from the memory controller.
// Optional instruction cache is enabled by defining ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_LEN-1:0]   pc,
  input  logic [5:0]            stall,
  input  logic                  JumpFlag,
  input  logic                  mem_if_valid,
  input  logic [BYTE_LEN-1:0]   mem_if_byte,
  output logic                  if_mem_req,
  output logic [ADDR_LEN-1:0]   if_mem_addr,
  output logic                  if_stall_req,
  output logic [ADDR_LEN-1:0]   if_pc,
  output logic [INST_LEN-1:0]   if_inst,
  output logic                  if_inst_valid
);

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
    $error("ICACHE_LINES must be a power of two");
  end

  if_state_e           state;
  logic [1:0]          cnt;
  logic [23:0]         inst_buf;
  logic [ADDR_LEN-1:0] fetch_pc;

  logic [ADDR_LEN-1:0] pc_word;
  logic                jump;
  logic                last_byte;
  logic [INST_LEN-1:0] fetched_word;
  logic                cache_hit;
  logic [INST_LEN-1:0] cache_word;
  logic                unused_bits;

  assign pc_word      = {pc[ADDR_LEN-1:2], 2'b00};
  assign jump         = (JumpFlag == BRANCH_ENABLE);
  assign last_byte    = (state == IF_BUSY) && mem_if_valid && (cnt == 2'd3);
  assign fetched_word = assemble_word(inst_buf, mem_if_byte);
  assign unused_bits  = ^{pc[1:0], stall[5:2], stall[0]};

`ifdef ICACHE_EN
  logic fill_en;

  // A fetch killed by a branch on its final byte must not pollute the cache.
  assign fill_en = last_byte && !jump && (rst != RESET_ENABLE);

  if_fetch_icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (pc[ADDR_LEN-1:2]),
    .hit         (cache_hit),
    .rd_data     (cache_word),
    .fill_en     (fill_en),
    .fill_word   (fetch_pc[ADDR_LEN-1:2]),
    .fill_data   (fetched_word)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_word = ZERO_WORD;
`endif

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state         <= IF_IDLE;
      cnt           <= 2'd0;
      if_mem_req    <= 1'b0;
      if_mem_addr   <= '0;
      if_stall_req  <= 1'b0;
      if_pc         <= '0;
      if_inst       <= ZERO_WORD;
      if_inst_valid <= 1'b0;
    end else if (jump) begin
      // Redirect wins over everything, including a fetch completing this cycle.
      state         <= IF_IDLE;
      cnt           <= 2'd0;
      if_mem_req    <= 1'b0;
      if_stall_req  <= 1'b0;
      if_inst       <= ZERO_WORD;
      if_inst_valid <= 1'b0;
    end else begin
      case (state)
        IF_IDLE: begin
          if_inst_valid <= 1'b0;
          if (!stall[1]) begin
            if (cache_hit) begin
              state         <= IF_DONE;
              if_pc         <= pc_word;
              if_inst       <= cache_word;
              if_inst_valid <= 1'b1;
            end else begin
              state        <= IF_BUSY;
              fetch_pc     <= pc_word;
              if_mem_addr  <= pc_word;
              if_mem_req   <= 1'b1;
              if_stall_req <= 1'b1;
              cnt          <= 2'd0;
            end
          end
        end
        IF_BUSY: begin
          if (mem_if_valid) begin
            cnt <= cnt + 2'd1;
            case (cnt)
              2'd0: inst_buf[7:0]   <= mem_if_byte;
              2'd1: inst_buf[15:8]  <= mem_if_byte;
              2'd2: inst_buf[23:16] <= mem_if_byte;
              default: begin
                state         <= IF_DONE;
                cnt           <= 2'd0;
                if_mem_req    <= 1'b0;
                if_stall_req  <= 1'b0;
                if_pc         <= fetch_pc;
                if_inst       <= fetched_word;
                if_inst_valid <= 1'b1;
              end
            endcase
          end
        end
        IF_DONE: begin
          if (!stall[1]) begin
            state         <= IF_IDLE;
            if_inst_valid <= 1'b0;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized fetches,
// with a memory/cache reference model and a scoreboard-driven output monitor.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic        JumpFlag;
  logic        mem_if_valid;
  logic [7:0]  mem_if_byte;
  logic        if_mem_req;
  logic [31:0] if_mem_addr;
  logic        if_stall_req;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_inst_valid;

  always #5 clk = ~clk;

  if_fetch #(.ICACHE_LINES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .stall         (stall),
    .JumpFlag      (JumpFlag),
    .mem_if_valid  (mem_if_valid),
    .mem_if_byte   (mem_if_byte),
    .if_mem_req    (if_mem_req),
    .if_mem_addr   (if_mem_addr),
    .if_stall_req  (if_stall_req),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_inst_valid (if_inst_valid)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_model [logic [31:0]];

`ifdef ICACHE_EN
  bit          cm_v   [64];
  logic [23:0] cm_tag [64];
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
`ifdef ICACHE_EN
    return cm_v[a[7:2]] && (cm_tag[a[7:2]] == a[31:8]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_fill(input logic [31:0] a);
`ifdef ICACHE_EN
    cm_v[a[7:2]]   = 1'b1;
    cm_tag[a[7:2]] = a[31:8];
`endif
  endtask

  task automatic model_reset();
`ifdef ICACHE_EN
    for (int i = 0; i < 64; i++) cm_v[i] = 1'b0;
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the IF/ID latch takes an instruction when it is valid and the stage is not stalled.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && if_inst_valid === 1'b1 && stall[1] === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual pc=0x%08h inst=0x%08h required no instruction",
                 if_pc, if_inst);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_inst", if_inst, e.inst);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check1({tag, "_req"}, if_mem_req, 1'b0);
    check({tag, "_addr"}, if_mem_addr, 32'h0);
    check1({tag, "_stall_req"}, if_stall_req, 1'b0);
    check({tag, "_pc"}, if_pc, 32'h0);
    check({tag, "_inst"}, if_inst, 32'h0);
    check1({tag, "_valid"}, if_inst_valid, 1'b0);
  endtask

  // One fetch. jump_at<0: no branch; else branch after jump_at bytes, or together
  // with byte jump_at when jump_with_byte is set. Stage is left parked (stall[1]=1).
  task automatic fetch(input logic [31:0] addr, input int gap, input int jump_at,
                       input bit jump_with_byte, input int stall_n);
    logic [31:0] word;
    bit          hit;
    bit          aborted;
    word    = mem_word(addr);
    hit     = model_hit(addr);
    aborted = 1'b0;
    pc = addr; stall = 6'b0; JumpFlag = 1'b0; mem_if_valid = 1'b0;
    if (jump_at < 0 || hit) exp_q.push_back('{pc: addr, inst: word});
    step();
    if (hit) begin
      check1("hit_no_req", if_mem_req, 1'b0);
      check1("hit_no_stall_req", if_stall_req, 1'b0);
      check1("hit_valid_2cyc", if_inst_valid, 1'b1);
    end else begin
      check1("req_start", if_mem_req, 1'b1);
      check("addr_start", if_mem_addr, addr);
      check1("stall_req_start", if_stall_req, 1'b1);
      for (int i = 0; i < 4 && !aborted; i++) begin
        for (int g = 0; g < gap; g++) begin
          step();
          check1("req_hold", if_mem_req, 1'b1);
          check("addr_hold", if_mem_addr, addr);
        end
        if (jump_at == i && !jump_with_byte) begin
          JumpFlag = 1'b1;
          step();
          JumpFlag = 1'b0;
          aborted  = 1'b1;
        end else begin
          mem_if_valid = 1'b1;
          mem_if_byte  = word[8*i +: 8];
          if (jump_at == i) JumpFlag = 1'b1;
          step();
          mem_if_valid = 1'b0;
          JumpFlag     = 1'b0;
          if (jump_at == i) aborted = 1'b1;
          else if (i < 3) begin
            check1("no_early_valid", if_inst_valid, 1'b0);
            check1("req_mid", if_mem_req, 1'b1);
          end
        end
      end
      if (aborted) begin
        stall = 6'b000010;
        check1("abort_req", if_mem_req, 1'b0);
        check1("abort_stall_req", if_stall_req, 1'b0);
        check1("abort_valid", if_inst_valid, 1'b0);
        check("abort_inst", if_inst, 32'h0);
        mem_if_valid = 1'b1;
        mem_if_byte  = 8'($urandom);
        step();
        step();
        mem_if_valid = 1'b0;
        check1("stray_req", if_mem_req, 1'b0);
        check1("stray_valid", if_inst_valid, 1'b0);
        step();
        return;
      end
      check1("valid_after_4th", if_inst_valid, 1'b1);
      check1("stall_req_done", if_stall_req, 1'b0);
      check1("req_done", if_mem_req, 1'b0);
      model_fill(addr);
    end
    if (stall_n > 0) begin
      stall = 6'b000010;
      for (int k = 0; k < stall_n; k++) begin
        check1("stall_hold_valid", if_inst_valid, 1'b1);
        check("stall_hold_inst", if_inst, word);
        check("stall_hold_pc", if_pc, addr);
        step();
      end
      stall = 6'b0;
      check1("stall_release_valid", if_inst_valid, 1'b1);
    end
    step();
    stall = 6'b000010;
    check1("idle_after_done", if_inst_valid, 1'b0);
  endtask

  task automatic reset_mid_fetch(input logic [31:0] addr);
    pc = addr; stall = 6'b0; JumpFlag = 1'b0;
    step();
    mem_if_valid = 1'b1;
    mem_if_byte  = 8'hAA;
    step();
    step();
    rst = 1'b1;
    step();
    check_outputs_zero("rst_mid");
    rst   = 1'b0;
    stall = 6'b000010;
    step();
    mem_if_valid = 1'b0;
    check1("post_rst_req", if_mem_req, 1'b0);
    check1("post_rst_valid", if_inst_valid, 1'b0);
    check1("post_rst_stall_req", if_stall_req, 1'b0);
    model_reset();
  endtask

  initial begin
    rst = 1'b1; stall = 6'b000010; JumpFlag = 1'b0;
    mem_if_valid = 1'b0; mem_if_byte = 8'h0; pc = 32'h0;
    model_reset();
    step();
    step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();
    check_outputs_zero("after_reset");

    mem_model[32'h0000_0000] = 32'h0000_0013;
    mem_model[32'h0000_0010] = 32'h0001_02B7;
    mem_model[32'h0000_0020] = 32'h00A0_0093;

    fetch(32'h0000_0000, 0, -1, 1'b0, 0);
    fetch(32'h0000_0010, 2, -1, 1'b0, 0);
    fetch(32'h0000_0080, 0, 2, 1'b0, 0);
    fetch(32'h0000_0040, 0, -1, 1'b0, 0);
    fetch(32'h0000_0084, 1, 3, 1'b1, 0);
    fetch(32'h0000_0044, 0, -1, 1'b0, 3);
    fetch(32'h0000_0020, 0, -1, 1'b0, 0);
    fetch(32'h0000_0020, 0, -1, 1'b0, 1);
    reset_mid_fetch(32'h0000_0030);
    fetch(32'h0000_0020, 0, -1, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          ja;
      a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      ja = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      fetch(a, int'($urandom_range(0, 2)), ja, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)));
    end

    step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
